// File: rtl/nn_result_tx.sv
// Serializes a 6-byte scoring report (header, yes/no counts, XOR checksum)
// as back-to-back 8N1 UART bytes on tx_data, snapshotting the counts on send.
`timescale 1ns/1ps

module nn_result_tx #(
  parameter int CLK_FREQ     = 25000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int CNT_BITS     = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                send,
  input  logic [CNT_BITS-1:0] yes,
  input  logic [CNT_BITS-1:0] no,
  output logic                tx_data,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  HEADER      = 8'hA5;
  localparam logic [2:0]  LAST_BYTE   = 3'd5;
  localparam logic [2:0]  LAST_BIT    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t              state_reg, state_next;
  logic [15:0]         baud_cnt_reg, baud_cnt_next;
  logic [2:0]          bit_idx_reg, bit_idx_next;
  logic [2:0]          byte_idx_reg, byte_idx_next;
  logic [CNT_BITS-1:0] yes_reg, yes_next;
  logic [CNT_BITS-1:0] no_reg, no_next;
  logic                tx_reg, tx_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                overrun_reg, overrun_next;

  logic [7:0] b1, b2, b3, b4, checksum;
  logic [7:0] cur_byte;
  logic       bit_end;

  // Frame bytes are derived from the snapshot, never from the live inputs.
  assign b1       = {2'b00, yes_reg[13:8]};
  assign b2       = yes_reg[7:0];
  assign b3       = {2'b00, no_reg[13:8]};
  assign b4       = no_reg[7:0];
  assign checksum = b1 ^ b2 ^ b3 ^ b4;
  assign bit_end  = (baud_cnt_reg == 16'd0);

  always_comb begin
    cur_byte = HEADER;
    case (byte_idx_reg)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = b1;
      3'd2:    cur_byte = b2;
      3'd3:    cur_byte = b3;
      3'd4:    cur_byte = b4;
      3'd5:    cur_byte = checksum;
      default: cur_byte = HEADER;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    byte_idx_next = byte_idx_reg;
    yes_next      = yes_reg;
    no_next       = no_reg;
    tx_next       = tx_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    overrun_next  = overrun_reg;

    // A request while not idle is dropped but remembered until reset.
    if (send && (state_reg != ST_IDLE)) begin
      overrun_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (send) begin
          state_next    = ST_START;
          baud_cnt_next = BAUD_RELOAD;
          bit_idx_next  = 3'd0;
          byte_idx_next = 3'd0;
          yes_next      = yes;
          no_next       = no;
          tx_next       = 1'b0;
          busy_next     = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_next    = ST_DATA;
          baud_cnt_next = BAUD_RELOAD;
          bit_idx_next  = 3'd0;
          tx_next       = cur_byte[0];
        end else begin
          baud_cnt_next = baud_cnt_reg - 16'd1;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          baud_cnt_next = BAUD_RELOAD;
          if (bit_idx_reg == LAST_BIT) begin
            state_next = ST_STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            tx_next      = cur_byte[bit_idx_reg + 3'd1];
          end
        end else begin
          baud_cnt_next = baud_cnt_reg - 16'd1;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (byte_idx_reg == LAST_BYTE) begin
            state_next    = ST_IDLE;
            baud_cnt_next = 16'd0;
            bit_idx_next  = 3'd0;
            byte_idx_next = 3'd0;
            tx_next       = 1'b1;
            busy_next     = 1'b0;
            done_next     = 1'b1;
          end else begin
            // No idle gap: the next start bit follows the stop bit directly.
            state_next    = ST_START;
            baud_cnt_next = BAUD_RELOAD;
            byte_idx_next = byte_idx_reg + 3'd1;
            tx_next       = 1'b0;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg - 16'd1;
        end
      end

      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= 16'd0;
      bit_idx_reg  <= 3'd0;
      byte_idx_reg <= 3'd0;
      yes_reg      <= '0;
      no_reg       <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      byte_idx_reg <= byte_idx_next;
      yes_reg      <= yes_next;
      no_reg       <= no_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      overrun_reg  <= overrun_next;
    end
  end

  assign tx_data = tx_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_nn_result_tx.sv
// Directed bench for nn_result_tx: a 4-clock-per-bit instance for frame-level
// checks and a default-baud instance decoded by a mid-bit sampling receiver.
`timescale 1ns/1ps

module tb_nn_result_tx;

  logic        clk = 1'b0;
  logic        rst_f, rst_s;
  logic        send_f, send_s;
  logic [13:0] yes_f, no_f, yes_s, no_s;
  logic        tx_f, busy_f, done_f, ovr_f;
  logic        tx_s, busy_s, done_s, ovr_s;

  int checks = 0;
  int errors = 0;

  localparam int SLOW_CPB = 217;

  nn_result_tx #(.CLKS_PER_BIT(4)) dut_fast (
    .clk(clk), .reset(rst_f), .send(send_f), .yes(yes_f), .no(no_f),
    .tx_data(tx_f), .busy(busy_f), .done(done_f), .overrun(ovr_f)
  );

  nn_result_tx dut_slow (
    .clk(clk), .reset(rst_s), .send(send_s), .yes(yes_s), .no(no_s),
    .tx_data(tx_s), .busy(busy_s), .done(done_s), .overrun(ovr_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame on the fast instance and checks every bit cell.
  task automatic run_frame_fast(input logic [47:0] exp, input int change_at,
                                input int resend_at, input logic exp_ovr,
                                input string name);
    int unstable;
    int busy_cnt;
    int done_cnt;
    logic [9:0] word;
    unstable = 0;
    busy_cnt = 0;
    done_cnt = 0;
    send_f = 1'b1;
    step();
    send_f = 1'b0;
    chk({name, "_start_tx"}, 32'(tx_f), 32'd0);
    chk({name, "_start_busy"}, 32'(busy_f), 32'd1);
    for (int b = 0; b < 6; b++) begin
      word = '0;
      for (int j = 0; j < 10; j++) begin
        for (int c = 0; c < 4; c++) begin
          int k;
          k = (b * 10 + j) * 4 + c;
          if (c == 0) word[j] = tx_f;
          else if (tx_f !== word[j]) unstable++;
          if (busy_f) busy_cnt++;
          if (done_f) done_cnt++;
          if (k == change_at) begin
            yes_f = 14'd0;
            no_f  = 14'd0;
          end
          send_f = (k == resend_at);
          step();
        end
      end
      chk($sformatf("%s_byte%0d", name, b), 32'(word), 32'({1'b1, exp[8*b +: 8], 1'b0}));
    end
    send_f = 1'b0;
    chk({name, "_bit_hold"}, 32'(unstable), 32'd0);
    chk({name, "_busy_len"}, 32'(busy_cnt), 32'd240);
    chk({name, "_early_done"}, 32'(done_cnt), 32'd0);
    chk({name, "_end_done"}, 32'(done_f), 32'd1);
    chk({name, "_end_busy"}, 32'(busy_f), 32'd0);
    chk({name, "_end_tx"}, 32'(tx_f), 32'd1);
    chk({name, "_overrun"}, 32'(ovr_f), 32'(exp_ovr));
    $display("frame %s: bytes %012h sent, overrun=%0b", name, exp, ovr_f);
  endtask

  // Watches the fast instance for n cycles and counts any activity.
  task automatic idle_watch(input int n, input string name);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      if (busy_f || done_f || (tx_f !== 1'b1)) act++;
      step();
    end
    chk({name, "_idle_activity"}, 32'(act), 32'd0);
  endtask

  initial begin
    int  ferr;
    int  w;
    logic [7:0] rx;
    logic [47:0] exp_s;

    rst_f = 1'b1; rst_s = 1'b1;
    send_f = 1'b0; send_s = 1'b0;
    yes_f = '0; no_f = '0; yes_s = '0; no_s = '0;
    step(); step();
    chk("rst_tx", 32'(tx_f), 32'd1);
    chk("rst_busy", 32'(busy_f), 32'd0);
    chk("rst_done", 32'(done_f), 32'd0);
    chk("rst_overrun", 32'(ovr_f), 32'd0);
    rst_f = 1'b0; rst_s = 1'b0;
    step();
    chk("idle_tx", 32'(tx_f), 32'd1);
    chk("slow_idle_tx", 32'(tx_s), 32'd1);

    // yes=100, no=23 -> A5 00 64 00 17, checksum 0x73
    yes_f = 14'd100; no_f = 14'd23;
    run_frame_fast(48'h73_17_00_64_00_A5, -1, -1, 1'b0, "basic");
    step();
    chk("basic_done_pulse", 32'(done_f), 32'd0);

    // Full-scale counts, inputs zeroed mid-frame -> A5 3F FF 3F FF 00
    yes_f = 14'h3FFF; no_f = 14'h3FFF;
    run_frame_fast(48'h00_FF_3F_FF_3F_A5, 30, -1, 1'b0, "max");
    step();
    chk("max_done_pulse", 32'(done_f), 32'd0);

    // Back-to-back: the second call raises send during the done cycle.
    yes_f = 14'd100; no_f = 14'd23;
    run_frame_fast(48'h73_17_00_64_00_A5, -1, -1, 1'b0, "b2b_1");
    run_frame_fast(48'h73_17_00_64_00_A5, -1, -1, 1'b0, "b2b_2");
    step();
    chk("b2b_done_pulse", 32'(done_f), 32'd0);

    // Second send 50 cycles into the frame.
    run_frame_fast(48'h73_17_00_64_00_A5, -1, 50, 1'b1, "ovr");
    step();
    idle_watch(100, "ovr");
    chk("ovr_sticky", 32'(ovr_f), 32'd1);

    // Reset during B2 (0x64) data bit 0, which is a 0 on the line.
    send_f = 1'b1;
    step();
    send_f = 1'b0;
    repeat (85) step();
    chk("rstmid_pre_tx", 32'(tx_f), 32'd0);
    #2 rst_f = 1'b1;
    #1;
    chk("rstmid_tx", 32'(tx_f), 32'd1);
    chk("rstmid_busy", 32'(busy_f), 32'd0);
    chk("rstmid_overrun", 32'(ovr_f), 32'd0);
    step();
    rst_f = 1'b0;
    step();
    idle_watch(300, "rstmid");
    run_frame_fast(48'h73_17_00_64_00_A5, -1, -1, 1'b0, "after_rst");
    step();

    // Default baud: yes=5000 (0x1388), no=777 (0x309) -> A5 13 88 03 09 91
    exp_s = 48'h91_09_03_88_13_A5;
    yes_s = 14'd5000; no_s = 14'd777;
    send_s = 1'b1;
    step();
    send_s = 1'b0;
    ferr = 0;
    for (int b = 0; b < 6; b++) begin
      w = 0;
      while ((tx_s !== 1'b0) && (w < 2 * SLOW_CPB)) begin
        step();
        w++;
      end
      chk($sformatf("slow_start_wait%0d", b), 32'(w < 2 * SLOW_CPB), 32'd1);
      repeat (SLOW_CPB / 2) step();
      if (tx_s !== 1'b0) ferr++;
      for (int i = 0; i < 8; i++) begin
        repeat (SLOW_CPB) step();
        rx[i] = tx_s;
      end
      repeat (SLOW_CPB) step();
      if (tx_s !== 1'b1) ferr++;
      chk($sformatf("slow_byte%0d", b), 32'(rx), 32'(exp_s[8*b +: 8]));
    end
    chk("slow_framing_errors", 32'(ferr), 32'd0);
    w = 0;
    while ((done_s !== 1'b1) && (w < SLOW_CPB)) begin
      step();
      w++;
    end
    chk("slow_done_seen", 32'(done_s), 32'd1);
    step();
    chk("slow_end_busy", 32'(busy_s), 32'd0);
    chk("slow_overrun", 32'(ovr_s), 32'd0);
    $display("frame slow: bytes %012h decoded, framing errors %0d", exp_s, ferr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
